// File: rtl/reg_file_sb_if.sv
// Register file bundle: two read ports, one write port, reservation request and busy count.
// The master drives addresses/strobes; the slave (register file) returns data, busy flags and acceptance.
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ok;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ok, busy_count
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ok, busy_count
    );
endinterface

// File: rtl/reg_file_sb.sv
// 2R1W register file with per-register busy scoreboard; reads combinational, writes land in 1 cycle.
// A reservation to a busy register is refused (rsv_ok=0) unless the same cycle's write frees it.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [CNT_W-1:0]  busy_count;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    logic wr_eff;
    logic rsv_ok;
    logic rsv_set;
    logic cnt_inc;
    logic cnt_dec;

    assign rd_addr[0] = bus.rd_addr1;
    assign rd_addr[1] = bus.rd_addr2;

    // Writes to the hardwired zero register are dropped entirely.
    assign wr_eff = bus.wr_en && !(HAS_ZERO && (bus.wr_addr == '0));

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
            if (HAS_ZERO && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if (HAS_BYP && bus.wr_en && (rd_addr[p] == bus.wr_addr)) begin
                rd_data[p] = bus.wr_data;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rsv_ok  = bus.rsv_en &&
                     (!busy[bus.rsv_addr] || (bus.wr_en && (bus.wr_addr == bus.rsv_addr)));
    assign rsv_set = rsv_ok && !(HAS_ZERO && (bus.rsv_addr == '0));

    // Reservation is applied after the write so a new producer wins over the landing one.
    always_comb begin
        busy_nxt = busy;
        if (wr_eff) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (rsv_set) begin
            busy_nxt[bus.rsv_addr] = 1'b1;
        end
    end

    assign cnt_inc = rsv_set && !busy[bus.rsv_addr];
    assign cnt_dec = wr_eff && busy[bus.wr_addr] &&
                     !(rsv_set && (bus.rsv_addr == bus.wr_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_eff) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
            busy       <= busy_nxt;
            busy_count <= busy_count + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        end
    end

    assign bus.rd_data1   = rd_data[0];
    assign bus.rd_data2   = rd_data[1];
    assign bus.rd_busy1   = rd_busy[0];
    assign bus.rd_busy2   = rd_busy[1];
    assign bus.rsv_ok     = rsv_ok;
    assign bus.busy_count = busy_count;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: unit a has bypass and no zero register, unit b has a
// hardwired zero register and no bypass; both share clock and reset.
module tb_reg_file_sb;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) a ();
    reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) b ();

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        a.rd_addr1 = '0; a.rd_addr2 = '0; a.wr_en = 1'b0; a.wr_addr = '0;
        a.wr_data  = '0; a.rsv_en   = 1'b0; a.rsv_addr = '0;
        b.rd_addr1 = '0; b.rd_addr2 = '0; b.wr_en = 1'b0; b.wr_addr = '0;
        b.wr_data  = '0; b.rsv_en   = 1'b0; b.rsv_addr = '0;
        #12;
        rst = 1'b0;
        tick();

        // Post-reset sweep of every address on unit a.
        for (int i = 0; i < 16; i++) begin
            a.rd_addr1 = 4'(i);
            a.rd_addr2 = 4'(15 - i);
            #1;
            chk("rst_data1", a.rd_data1, 32'h0);
            chk("rst_busy2", a.rd_busy2, 32'h0);
        end
        chk("rst_count", a.busy_count, 32'h0);
        tick();

        // Same-cycle write of r5 is forwarded on port 1.
        a.wr_en = 1'b1; a.wr_addr = 4'd5; a.wr_data = 16'hBEEF; a.rd_addr1 = 4'd5;
        #1;
        chk("byp_data", a.rd_data1, 32'hBEEF);
        tick();
        a.wr_en = 1'b0;
        #1;
        chk("r5_stored", a.rd_data1, 32'hBEEF);

        // Reserve r3, refuse a second reservation, then release it with a write.
        a.rsv_en = 1'b1; a.rsv_addr = 4'd3; a.rd_addr2 = 4'd3;
        #1;
        chk("rsv3_ok", a.rsv_ok, 32'h1);
        tick();
        chk("r3_busy", a.rd_busy2, 32'h1);
        chk("cnt_r3", a.busy_count, 32'h1);
        chk("rsv3_again", a.rsv_ok, 32'h0);
        tick();
        a.rsv_en = 1'b0;
        #1;
        chk("cnt_keep", a.busy_count, 32'h1);
        chk("r3_still", a.rd_busy2, 32'h1);
        a.wr_en = 1'b1; a.wr_addr = 4'd3; a.wr_data = 16'h1234;
        #1;
        chk("r3_byp_busy", a.rd_busy2, 32'h0);
        chk("r3_byp_data", a.rd_data2, 32'h1234);
        tick();
        a.wr_en = 1'b0;
        #1;
        chk("r3_free", a.rd_busy2, 32'h0);
        chk("cnt_r3_free", a.busy_count, 32'h0);
        chk("r3_data", a.rd_data2, 32'h1234);

        // Write and re-reserve busy r7 in one cycle: new producer keeps it busy.
        a.rsv_en = 1'b1; a.rsv_addr = 4'd7;
        tick();
        a.rsv_en = 1'b0;
        #1;
        chk("cnt_r7", a.busy_count, 32'h1);
        a.wr_en = 1'b1; a.wr_addr = 4'd7; a.wr_data = 16'h00AA;
        a.rsv_en = 1'b1; a.rsv_addr = 4'd7;
        #1;
        chk("r7_rsv_ok", a.rsv_ok, 32'h1);
        tick();
        a.wr_en = 1'b0; a.rsv_en = 1'b0; a.rd_addr1 = 4'd7;
        #1;
        chk("r7_data", a.rd_data1, 32'h00AA);
        chk("r7_busy", a.rd_busy1, 32'h1);
        chk("cnt_r7_same", a.busy_count, 32'h1);
        a.wr_en = 1'b1; a.wr_addr = 4'd7; a.wr_data = 16'h00AB;
        tick();
        a.wr_en = 1'b0;
        #1;
        chk("cnt_r7_free", a.busy_count, 32'h0);

        // Fill the whole scoreboard, then drain it one write per cycle.
        for (int i = 0; i < 16; i++) begin
            a.rsv_en = 1'b1; a.rsv_addr = 4'(i);
            tick();
        end
        a.rsv_en = 1'b0; a.rd_addr1 = 4'd0;
        #1;
        chk("cnt_full", a.busy_count, 32'd16);
        chk("r0_busy_a", a.rd_busy1, 32'h1);
        for (int i = 0; i < 16; i++) begin
            a.wr_en = 1'b1; a.wr_addr = 4'(i); a.wr_data = 16'(i * 16'h0111);
            tick();
            chk("cnt_drain", a.busy_count, 32'(15 - i));
        end
        a.wr_en = 1'b0;

        // Leave r2 and r9 reserved on unit a for the reset check at the end.
        a.rsv_en = 1'b1; a.rsv_addr = 4'd2;
        tick();
        a.rsv_addr = 4'd9;
        tick();
        a.rsv_en = 1'b0;
        #1;
        chk("cnt_two", a.busy_count, 32'd2);

        // Unit b: no bypass, so the write shows up one cycle later.
        b.wr_en = 1'b1; b.wr_addr = 4'd5; b.wr_data = 16'hBEEF; b.rd_addr1 = 4'd5;
        #1;
        chk("nobyp_old", b.rd_data1, 32'h0);
        tick();
        b.wr_en = 1'b0;
        #1;
        chk("nobyp_new", b.rd_data1, 32'hBEEF);

        // Zero register ignores writes and reservations.
        b.wr_en = 1'b1; b.wr_addr = 4'd0; b.wr_data = 16'hFFFF;
        b.rsv_en = 1'b1; b.rsv_addr = 4'd0; b.rd_addr1 = 4'd0;
        #1;
        chk("z_rsv_ok", b.rsv_ok, 32'h1);
        chk("z_data_now", b.rd_data1, 32'h0);
        tick();
        b.wr_en = 1'b0; b.rsv_en = 1'b0;
        #1;
        chk("z_data", b.rd_data1, 32'h0);
        chk("z_busy", b.rd_busy1, 32'h0);
        chk("z_count", b.busy_count, 32'h0);

        // Reserving every address on b saturates at 15 because r0 never counts.
        for (int i = 0; i < 16; i++) begin
            b.rsv_en = 1'b1; b.rsv_addr = 4'(i);
            tick();
        end
        b.rsv_en = 1'b0;
        #1;
        chk("z_cnt_full", b.busy_count, 32'd15);
        b.wr_en = 1'b1; b.wr_addr = 4'd4; b.wr_data = 16'h4444; b.rd_addr2 = 4'd4;
        #1;
        chk("nobyp_busy", b.rd_busy2, 32'h1);
        tick();
        b.wr_en = 1'b0;
        #1;
        chk("r4_free", b.rd_busy2, 32'h0);
        chk("z_cnt_14", b.busy_count, 32'd14);

        // Asynchronous reset between clock edges clears everything at once.
        a.rd_addr1 = 4'd2; a.rd_addr2 = 4'd5; b.rd_addr1 = 4'd5;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_cnt_a", a.busy_count, 32'h0);
        chk("arst_busy_a", a.rd_busy1, 32'h0);
        chk("arst_data_a", a.rd_data2, 32'h0);
        chk("arst_cnt_b", b.busy_count, 32'h0);
        chk("arst_data_b", b.rd_data1, 32'h0);
        #5;
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised synchronous register file for the CPU datapath, with two read ports and one write port. It replaces the enable-edge-written 16x16 register file with a properly clocked array. It adds configurable width/depth, an optional hardwired zero register, and optional write-to-read bypass. A per-register busy scoreboard lets the issue logic reserve a destination register and stall readers until the producing write lands.

Parameters:
DATA_W, 16, data width of each register
ADDR_W, 4, address width; depth = 2**ADDR_W
ZERO_REG, 0, if 1 register 0 always reads 0, ignores writes and is never busy
BYPASS, 1, if 1 a same-cycle write is forwarded to matching read ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
rd_addr1  input  ADDR_W  read port 1 address
rd_addr2  input  ADDR_W  read port 2 address
rd_data1  output  DATA_W  read port 1 data (combinational)
rd_data2  output  DATA_W  read port 2 data (combinational)
rd_busy1  output  1  register at rd_addr1 awaits a pending write
rd_busy2  output  1  register at rd_addr2 awaits a pending write
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rsv_en  input  1  reserve request: mark rsv_addr busy
rsv_addr  input  ADDR_W  register to reserve
rsv_ok  output  1  reservation accepted this cycle (combinational)
busy_count  output  ADDR_W+1  number of currently busy registers (registered)

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: all registers = 0, all busy bits = 0, busy_count = 0, applied immediately on rst assertion, with no clock needed. rd_data*/rd_busy* then reflect the cleared state combinationally. A reset mid-reservation drops all pending reservations.
- Write: on posedge clk with wr_en=1, regs[wr_addr] <= wr_data, and busy[wr_addr] is cleared unless re-reserved in the same cycle (see below). Write latency is 1 cycle.
- Read: rd_dataN = regs[rd_addrN], combinational.
  - If BYPASS=1 and wr_en=1 and rd_addrN==wr_addr, rd_dataN = wr_data.
  - If BYPASS=0, the new value is visible the cycle after the write.
- rd_busyN = busy[rd_addrN].
  - If BYPASS=1 and wr_en=1 and rd_addrN==wr_addr, rd_busyN = 0, because the data is forwarded.
- ZERO_REG=1, address 0:
  - reads return 0 and rd_busy=0, and bypass is never applied;
  - writes are discarded;
  - a reservation returns rsv_ok=1 but sets no busy bit.
- Reservation:
  - rsv_ok = rsv_en & (~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr)).
  - When rsv_ok=1, busy[rsv_addr] <= 1 at the next posedge.
  - When rsv_en=1 and the register is busy with no same-cycle write to it, rsv_ok=0 and the state is unchanged. The requester must retry.
- Simultaneous write and reserve to the same address: the data is written and the busy bit ends up 1, because the new producer wins.
- A write to a non-busy register is legal and leaves busy at 0.
- busy_count is updated each posedge by +1 for an accepted reservation that sets a bit previously 0, and -1 for a write that clears a bit previously 1.
  - Net change per cycle is in {-1, 0, +1}. A simultaneous write+reserve to the same busy register gives 0.
  - It never exceeds 2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG=1.
  - busy_count always equals the popcount of the busy bits.
- No X propagation: uninitialised reads are impossible after reset.

Test Plan:
- Reset, then read all 16 addresses -> rd_data=0x0000, rd_busy=0, busy_count=0; assert rst mid-test with busy bits set -> busy_count=0 immediately, without waiting for a clock edge.
- Write 0xBEEF to r5 while reading r5 on port 1 in the same cycle -> BYPASS=1: rd_data1=0xBEEF that cycle; BYPASS=0: old value, then 0xBEEF next cycle.
- Reserve r3 -> rsv_ok=1, next cycle rd_busy2 (addr 3)=1, busy_count=1; reserve r3 again -> rsv_ok=0 and busy_count stays 1; write r3=0x1234 -> busy cleared, busy_count=0, data=0x1234.
- Same cycle: wr_en r7=0x00AA with rsv_en r7, where r7 was busy -> rsv_ok=1, r7=0x00AA, r7 still busy, busy_count unchanged.
- ZERO_REG=1: write 0xFFFF to r0, reserve r0 -> rd_data of r0=0, rsv_ok=1, rd_busy=0, busy_count=0.
- Reserve all 16 registers over 16 cycles -> busy_count=16 (width 5, no wrap); write them back one per cycle -> count decrements to 0.
